mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of a single shared mem_system (unified cache plus four-bank memory).
- Accepts fetch reads from the instruction port and loads/stores from the data port, and grants one at a time.
- Drives a stable Addr/DataIn/Rd/Wr to the memory until Done (or err, or timeout), then steers the result back to the owner.
- Data port has priority; an anti-starvation counter guarantees fetch progress. A watchdog converts a hung access into an error completion.

Parameters:
MAX_WAIT, 4, consecutive data grants allowed while an instruction request waits; once reached, the next grant goes to the instruction port.
TIMEOUT, 64, cycles allowed in a BUSY state before forced error completion; counter width is $clog2(TIMEOUT+1).

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset; asynchronous, active-low
i_req  input  1  instruction read request; held high until i_done
i_addr  input  16  instruction address
d_req  input  1  data request; held high until d_done
d_wr  input  1  1 = store, 0 = load; valid while d_req is high
d_addr  input  16  data address
d_wdata  input  16  store data
i_done  output  1  instruction access complete (one-cycle pulse)
i_rdata  output  16  instruction read data; valid only when i_done is high
i_err  output  1  instruction access failed; valid only when i_done is high
d_done  output  1  data access complete (one-cycle pulse)
d_rdata  output  16  load data; valid only when d_done is high
d_err  output  1  data access failed; valid only when d_done is high
m_addr  output  16  to mem_system Addr
m_wdata  output  16  to mem_system DataIn
m_rd  output  1  to mem_system Rd
m_wr  output  1  to mem_system Wr
m_rdata  input  16  from mem_system DataOut
m_done  input  1  from mem_system Done
m_stall  input  1  from mem_system Stall (monitor only; not used for control)
m_err  input  1  from mem_system err

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset (rst low, asynchronous):
  - state = IDLE; starve_cnt = 0; tmo_cnt = 0.
  - Capture registers (addr, wdata, wr) cleared to 0.
  - All outputs 0.
- IDLE:
  - m_rd = m_wr = 0.
  - Grant decision, evaluated each cycle:
    - d_req & ~(i_req & starve_cnt == MAX_WAIT) -> BUSY_D.
    - else i_req -> BUSY_I.
    - else stay in IDLE.
  - On grant, capture the winner's addr (plus wdata/wr for data) into registers. tmo_cnt is cleared on entry to either BUSY state.
- starve_cnt (saturates at MAX_WAIT):
  - Incremented on each BUSY_D grant made while i_req is high.
  - Cleared on every BUSY_I grant.
  - Cleared on any IDLE cycle with i_req low.
- BUSY_I:
  - m_addr = captured addr; m_rd = 1; m_wr = 0; m_wdata = 0.
- BUSY_D:
  - m_addr / m_wdata from the capture registers.
  - m_wr = captured wr; m_rd = ~captured wr.
- Rd/Wr stay asserted every BUSY cycle; mem_system ignores them while it is mid-miss.
- Completion (combinational, in the same cycle):
  - Condition: m_done | m_err | (tmo_cnt == TIMEOUT).
  - Owner's done = 1.
  - Owner's rdata = m_rdata (0 for stores).
  - Owner's err = m_err | timeout, and m_done is ignored when err is set.
  - Next state is IDLE, always.
  - The non-owner's done/rdata/err stay 0.
- IDLE gap: the IDLE cycle after every completion is mandatory.
  - It lets the requester drop or renew its req before re-arbitration.
  - It ensures mem_system sees Rd/Wr low at least one cycle, so no duplicate access.
  - Peak throughput is therefore one access per 2 cycles.
- Latency, req rising (IDLE) to done:
  - Cache hit: 1 cycle (done in the first BUSY cycle).
  - Miss: 1 + mem_system miss latency.
- tmo_cnt: increments each BUSY cycle without completion.
- Reset asserted mid-access:
  - Immediate return to IDLE with all outputs 0.
  - The pending access is abandoned; mem_system is reset by the same net.
- A requester dropping req while granted is a protocol violation. The access still completes and done still pulses.
- Simultaneous i_req and d_req with starve_cnt < MAX_WAIT -> data wins.

Test Plan:
1. Reset held low, then released with no requests -> all outputs 0, m_rd = m_wr = 0 for 10 cycles.
2. i_req with i_addr = 0x0040, m_done returned in the first BUSY cycle with m_rdata = 0x1234 -> m_rd = 1 and m_addr = 0x0040 one cycle after req; i_done = 1 with i_rdata = 0x1234 in that same cycle; IDLE on the next cycle.
3. Store d_addr = 0x0100, d_wdata = 0xBEEF, with m_done delayed 20 cycles (miss) -> m_wr = 1 held for all 20 BUSY cycles with address/data stable; d_done pulses once; i_done stays 0.
4. i_req and d_req both held continuously, MAX_WAIT = 4 -> grant sequence is D, D, D, D, I, D, D, D, D, I…; each grant is separated by one IDLE cycle.
5. m_done never asserted, TIMEOUT = 64 -> d_done = d_err = 1 exactly on the 65th BUSY cycle; then IDLE.
6. m_err pulsed mid-access, then a separate test with rst driven low during BUSY_I -> first case: i_done = i_err = 1 that cycle; second case: i_done stays 0 and state is IDLE after reset releases.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of a shared mem_system.
// Data port has priority; a starvation counter and a watchdog bound fetch and access latency.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_done,
  output logic [15:0] i_rdata,
  output logic        i_err,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        d_err,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [15:0] m_rdata,
  input  logic        m_done,
  input  logic        m_stall,
  input  logic        m_err
);

  localparam int unsigned StarveW = $clog2(MAX_WAIT + 1);
  localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);

  localparam logic [StarveW-1:0] MaxWaitC = StarveW'(MAX_WAIT);
  localparam logic [TmoW-1:0]    TimeoutC = TmoW'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } state_e;

  state_e              state_q, state_d;
  logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [15:0]         addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                wr_q, wr_d;

  logic idle;
  logic busy;
  logic timeout;
  logic complete;
  logic acc_err;
  logic starved;
  logic grant_d;
  logic grant_i;

  // Stall is informational only; completion is signalled by done/err.
  logic unused_stall;
  assign unused_stall = m_stall;

  assign idle     = (state_q == StIdle);
  assign busy     = (state_q == StBusyI) || (state_q == StBusyD);
  assign timeout  = (tmo_cnt_q == TimeoutC);
  assign complete = busy && (m_done || m_err || timeout);
  assign acc_err  = m_err || timeout;

  // Instruction port wins only once the data port has used up its allowance.
  assign starved  = i_req && (starve_cnt_q == MaxWaitC);
  assign grant_d  = idle && d_req && !starved;
  assign grant_i  = idle && !grant_d && i_req;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;

    unique case (state_q)
      StIdle: begin
        if (!i_req) begin
          starve_cnt_d = '0;
        end
        if (grant_d) begin
          state_d   = StBusyD;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          wr_d      = d_wr;
          tmo_cnt_d = '0;
          if (i_req && (starve_cnt_q != MaxWaitC)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (grant_i) begin
          state_d      = StBusyI;
          addr_d       = i_addr;
          wdata_d      = '0;
          wr_d         = 1'b0;
          tmo_cnt_d    = '0;
          starve_cnt_d = '0;
        end
      end
      StBusyI, StBusyD: begin
        // Always return through IDLE so Rd/Wr drop for a cycle between accesses.
        if (complete) begin
          state_d = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them immediately.
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    i_done  = 1'b0;
    i_rdata = '0;
    i_err   = 1'b0;
    d_done  = 1'b0;
    d_rdata = '0;
    d_err   = 1'b0;

    unique case (state_q)
      StBusyI: begin
        m_addr = addr_q;
        m_rd   = 1'b1;
        if (complete) begin
          i_done  = 1'b1;
          i_rdata = m_rdata;
          i_err   = acc_err;
        end
      end
      StBusyD: begin
        m_addr  = addr_q;
        m_wdata = wdata_q;
        m_wr    = wr_q;
        m_rd    = !wr_q;
        if (complete) begin
          d_done  = 1'b1;
          d_rdata = wr_q ? 16'h0000 : m_rdata;
          d_err   = acc_err;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions, a negedge monitor
// pops and compares them whenever either done output fires.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        i_err;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        d_err;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_rdata;
  logic        m_done;
  logic        m_stall;
  logic        m_err;

  mem_arbiter #(
    .MAX_WAIT(4),
    .TIMEOUT (64)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_req  (i_req),
    .i_addr (i_addr),
    .d_req  (d_req),
    .d_wr   (d_wr),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .i_done (i_done),
    .i_rdata(i_rdata),
    .i_err  (i_err),
    .d_done (d_done),
    .d_rdata(d_rdata),
    .d_err  (d_err),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rd   (m_rd),
    .m_wr   (m_wr),
    .m_rdata(m_rdata),
    .m_done (m_done),
    .m_stall(m_stall),
    .m_err  (m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // port: 0 = instruction, 1 = data
  typedef struct packed {
    logic        port;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic expect_done(input logic port, input logic [15:0] rdata, input logic err);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{i_done, i_rdata, i_err, d_done, d_rdata, d_err, m_addr, m_wdata, m_rd, m_wr};
  endfunction

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic cur;
    exp_t e;
    cur = i_done | d_done;
    if (rst && cur) begin
      chk("one_owner", {63'd0, i_done & d_done}, 64'd0);
      chk("idle_gap", {63'd0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_done", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_done", {46'd0, d_done, d_done ? d_rdata : i_rdata, d_done ? d_err : i_err},
            {46'd0, e.port, e.rdata, e.err});
      end
    end
    prev_done = rst ? cur : 1'b0;
  end

  initial begin
    rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0;
    d_wdata = '0; m_rdata = '0; m_done = 1'b0; m_stall = 1'b0; m_err = 1'b0;

    // 1: reset, then idle with no requests
    @(negedge clk);
    chk("t1_in_reset", {63'd0, any_out()}, 64'd0);
    tick; tick;
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t1_idle_outs", {63'd0, any_out()}, 64'd0);
    end

    // 2: instruction hit
    tick;
    i_req = 1'b1; i_addr = 16'h0040;
    tick;
    m_done = 1'b1; m_rdata = 16'h1234;
    expect_done(1'b0, 16'h1234, 1'b0);
    @(negedge clk);
    chk("t2_rd_addr", {47'd0, m_rd, m_addr}, {47'd0, 1'b1, 16'h0040});
    tick;
    i_req = 1'b0; m_done = 1'b0; m_rdata = '0;
    @(negedge clk);
    chk("t2_idle_after", {62'd0, m_rd, m_wr}, 64'd0);

    // 3: store miss, memory answers on the 20th busy cycle
    tick;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF; m_rdata = 16'h5555;
    tick;
    d_addr = 16'hFFFF; d_wdata = 16'h0000;
    for (int k = 1; k <= 20; k++) begin
      if (k == 20) begin
        m_done = 1'b1;
        expect_done(1'b1, 16'h0000, 1'b0);
      end
      @(negedge clk);
      chk("t3_store_hold", {30'd0, m_wr, m_rd, m_addr, m_wdata},
          {30'd0, 1'b1, 1'b0, 16'h0100, 16'hBEEF});
      if (k < 20) tick;
    end
    tick;
    d_req = 1'b0; d_wr = 1'b0; m_done = 1'b0; m_rdata = '0;
    @(negedge clk);
    chk("t3_idle_after", {62'd0, m_rd, m_wr}, 64'd0);

    // 4: both ports held, all hits: D D D D I D D D D I
    tick;
    i_req = 1'b1; i_addr = 16'h0200; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
    m_done = 1'b1; m_rdata = 16'h00AA;
    for (int g = 0; g < 10; g++) begin
      expect_done((g % 5) != 4, 16'h00AA, 1'b0);
    end
    repeat (20) @(posedge clk);
    #1;
    i_req = 1'b0; d_req = 1'b0; m_done = 1'b0; m_rdata = '0;
    @(negedge clk);
    chk("t4_idle_after", {62'd0, m_rd, m_wr}, 64'd0);

    // 5: watchdog on a load that never completes
    tick;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
    expect_done(1'b1, 16'h0000, 1'b1);
    repeat (64) @(posedge clk);
    @(negedge clk);
    chk("t5_cycle64_no_done", {63'd0, d_done}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_cycle65_timeout", {62'd0, d_done, d_err}, 64'd3);
    tick;
    d_req = 1'b0;
    @(negedge clk);
    chk("t5_idle_after", {62'd0, m_rd, m_wr}, 64'd0);

    // 6a: m_err on the 2nd busy cycle of a fetch
    tick;
    i_req = 1'b1; i_addr = 16'h0500;
    tick;
    tick;
    m_err = 1'b1; m_done = 1'b1; m_rdata = 16'h0BAD;
    expect_done(1'b0, 16'h0BAD, 1'b1);
    @(negedge clk);
    chk("t6_err_done", {62'd0, i_done, i_err}, 64'd3);
    tick;
    i_req = 1'b0; m_err = 1'b0; m_done = 1'b0; m_rdata = '0;

    // 6b: reset asserted during BUSY_I
    tick;
    i_req = 1'b1; i_addr = 16'h0600;
    tick;
    @(negedge clk);
    chk("t6_busy_rd", {47'd0, m_rd, m_addr}, {47'd0, 1'b1, 16'h0600});
    rst = 1'b0;
    #1;
    chk("t6_async_clear", {63'd0, any_out()}, 64'd0);
    tick;
    i_req = 1'b0;
    tick;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_idle_after_rst", {63'd0, any_out()}, 64'd0);
    end

    repeat (3) tick;
    chk("sb_all_consumed", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
